// File: rtl/video_channel_mux_pkg.sv
// Plane encodings and reset-default display configuration shared by the channel mux.
package video_channel_mux_pkg;

  localparam logic [2:0] PLANE_RGB = 3'd0;
  localparam logic [2:0] PLANE_Y   = 3'd1;
  localparam logic [2:0] PLANE_CR  = 3'd2;
  localparam logic [2:0] PLANE_CB  = 3'd3;
  localparam logic [2:0] PLANE_H   = 3'd4;
  localparam logic [2:0] PLANE_S   = 3'd5;
  localparam logic [2:0] PLANE_V   = 3'd6;

  localparam int         DEF_CH    = 0;
  localparam logic [2:0] DEF_PLANE = PLANE_RGB;
  localparam logic       DEF_SPLIT = 1'b0;

endpackage

// File: rtl/video_channel_mux_sel_sync_latch.sv
// Synchronises the switch request and loads it into the active config at frame start.
// Latency: request to req 2 cycles, req to pending/err flags 1 more; load on frame-start edge.
// Backpressure: none; the request is sampled every cycle.
module sel_sync_latch
  import video_channel_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int NUM_GRAY = 6,
  parameter int CH_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_W-1:0] sel_ch,
  input  logic [2:0]      sel_plane,
  input  logic            sel_split,
  input  logic            frame_start,
  output logic [CH_W-1:0] cfg_ch,
  output logic [2:0]      cfg_plane,
  output logic            cfg_split,
  output logic            pending,
  output logic            sel_err
);

  localparam int REQ_W = CH_W + 4;

  logic [REQ_W-1:0] sync_1;
  logic [REQ_W-1:0] sync_2;
  logic [CH_W-1:0]  req_ch;
  logic [2:0]       req_plane;
  logic             req_split;
  logic             req_valid;
  logic             req_differs;

  assign req_ch    = sync_2[REQ_W-1:4];
  assign req_plane = sync_2[3:1];
  assign req_split = sync_2[0];

  // 32-bit compare so a CH_W that exactly fits NUM_CH-1 cannot wrap the bound
  assign req_valid   = (32'(req_ch) < NUM_CH) && (32'(req_plane) <= NUM_GRAY);
  assign req_differs = (req_ch != cfg_ch) || (req_plane != cfg_plane) || (req_split != cfg_split);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {sel_ch, sel_plane, sel_split};
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ch    <= CH_W'(DEF_CH);
      cfg_plane <= DEF_PLANE;
      cfg_split <= DEF_SPLIT;
      pending   <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (frame_start && req_valid) begin
        cfg_ch    <= req_ch;
        cfg_plane <= req_plane;
        cfg_split <= req_split;
      end
      pending <= req_valid && req_differs;
      sel_err <= !req_valid;
    end
  end

endmodule

// File: rtl/video_channel_mux.sv
// Selects one camera channel (RGB or a grey plane, optionally split-screen) for the VGA controller.
// Latency: 2 cycles from iX/iDVAL/pixel data to oR/oG/oB/oDVAL, 1 pixel per cycle.
// Backpressure: none; the pipeline never stalls.
module video_channel_mux
  import video_channel_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int NUM_GRAY = 6,
  parameter int PIX_W    = 10,
  parameter int X_W      = 11,
  parameter int SPLIT_X  = 320,
  parameter int CH_W     = 2
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [CH_W-1:0]            iSEL_CH,
  input  logic [2:0]                 iSEL_PLANE,
  input  logic                       iSPLIT,
  input  logic                       iFRAME_START,
  input  logic [X_W-1:0]             iX,
  input  logic                       iDVAL,
  input  logic [NUM_CH*PIX_W-1:0]    iR,
  input  logic [NUM_CH*PIX_W-1:0]    iG,
  input  logic [NUM_CH*PIX_W-1:0]    iB,
  input  logic [NUM_CH*NUM_GRAY*8-1:0] iGRAY,
  output logic [PIX_W-1:0]           oR,
  output logic [PIX_W-1:0]           oG,
  output logic [PIX_W-1:0]           oB,
  output logic                       oDVAL,
  output logic [CH_W-1:0]            oCFG_CH,
  output logic [2:0]                 oCFG_PLANE,
  output logic                       oCFG_SPLIT,
  output logic                       oPENDING,
  output logic                       oSEL_ERR
);

  logic [CH_W-1:0]  ch_b;
  logic [CH_W-1:0]  src_ch;
  logic [PIX_W-1:0] r_sel, g_sel, b_sel;
  logic [7:0]       gray_sel;

  logic [PIX_W-1:0] r_s1, g_s1, b_s1;
  logic [7:0]       gray_s1;
  logic [2:0]       plane_s1;
  logic             dval_s1;

  sel_sync_latch #(
    .NUM_CH   (NUM_CH),
    .NUM_GRAY (NUM_GRAY),
    .CH_W     (CH_W)
  ) u_sel (
    .clk         (iCLK),
    .rst_n       (iRST_N),
    .sel_ch      (iSEL_CH),
    .sel_plane   (iSEL_PLANE),
    .sel_split   (iSPLIT),
    .frame_start (iFRAME_START),
    .cfg_ch      (oCFG_CH),
    .cfg_plane   (oCFG_PLANE),
    .cfg_split   (oCFG_SPLIT),
    .pending     (oPENDING),
    .sel_err     (oSEL_ERR)
  );

  assign ch_b   = (oCFG_CH == CH_W'(NUM_CH - 1)) ? '0 : oCFG_CH + 1'b1;
  assign src_ch = (oCFG_SPLIT && (iX >= X_W'(SPLIT_X))) ? ch_b : oCFG_CH;

  // Loop-decoded muxes keep every slice index constant
  always_comb begin
    r_sel    = '0;
    g_sel    = '0;
    b_sel    = '0;
    gray_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_ch == CH_W'(c)) begin
        r_sel = iR[c*PIX_W +: PIX_W];
        g_sel = iG[c*PIX_W +: PIX_W];
        b_sel = iB[c*PIX_W +: PIX_W];
        for (int p = 0; p < NUM_GRAY; p++) begin
          if (oCFG_PLANE == 3'(p + 1)) gray_sel = iGRAY[(c*NUM_GRAY + p)*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1     <= '0;
      g_s1     <= '0;
      b_s1     <= '0;
      gray_s1  <= '0;
      plane_s1 <= PLANE_RGB;
      dval_s1  <= 1'b0;
    end else begin
      r_s1     <= r_sel;
      g_s1     <= g_sel;
      b_s1     <= b_sel;
      gray_s1  <= gray_sel;
      plane_s1 <= oCFG_PLANE;
      dval_s1  <= iDVAL;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oR    <= '0;
      oG    <= '0;
      oB    <= '0;
      oDVAL <= 1'b0;
    end else begin
      oDVAL <= dval_s1;
      if (!dval_s1) begin
        oR <= '0;
        oG <= '0;
        oB <= '0;
      end else if (plane_s1 == PLANE_RGB) begin
        oR <= r_s1;
        oG <= g_s1;
        oB <= b_s1;
      end else begin
        oR <= PIX_W'(gray_s1) << (PIX_W - 8);
        oG <= PIX_W'(gray_s1) << (PIX_W - 8);
        oB <= PIX_W'(gray_s1) << (PIX_W - 8);
      end
    end
  end

endmodule

// File: tb/tb_video_channel_mux.sv
// Directed bench for video_channel_mux with the default 2-channel, 10-bit configuration.
module tb_video_channel_mux;

  localparam int NUM_CH   = 2;
  localparam int NUM_GRAY = 6;
  localparam int PIX_W    = 10;
  localparam int X_W      = 11;
  localparam int SPLIT_X  = 320;
  localparam int CH_W     = 2;

  logic                         iCLK = 1'b0;
  logic                         iRST_N;
  logic [CH_W-1:0]              iSEL_CH;
  logic [2:0]                   iSEL_PLANE;
  logic                         iSPLIT;
  logic                         iFRAME_START;
  logic [X_W-1:0]               iX;
  logic                         iDVAL;
  logic [NUM_CH*PIX_W-1:0]      iR, iG, iB;
  logic [NUM_CH*NUM_GRAY*8-1:0] iGRAY;
  logic [PIX_W-1:0]             oR, oG, oB;
  logic                         oDVAL;
  logic [CH_W-1:0]              oCFG_CH;
  logic [2:0]                   oCFG_PLANE;
  logic                         oCFG_SPLIT;
  logic                         oPENDING;
  logic                         oSEL_ERR;

  int checks = 0;
  int errors = 0;

  video_channel_mux #(
    .NUM_CH(NUM_CH), .NUM_GRAY(NUM_GRAY), .PIX_W(PIX_W),
    .X_W(X_W), .SPLIT_X(SPLIT_X), .CH_W(CH_W)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSEL_CH(iSEL_CH), .iSEL_PLANE(iSEL_PLANE),
    .iSPLIT(iSPLIT), .iFRAME_START(iFRAME_START), .iX(iX), .iDVAL(iDVAL),
    .iR(iR), .iG(iG), .iB(iB), .iGRAY(iGRAY),
    .oR(oR), .oG(oG), .oB(oB), .oDVAL(oDVAL),
    .oCFG_CH(oCFG_CH), .oCFG_PLANE(oCFG_PLANE), .oCFG_SPLIT(oCFG_SPLIT),
    .oPENDING(oPENDING), .oSEL_ERR(oSEL_ERR)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic request(input logic [CH_W-1:0] ch, input logic [2:0] pl, input logic sp);
    iSEL_CH = ch; iSEL_PLANE = pl; iSPLIT = sp;
  endtask

  task automatic load_cfg(input logic [CH_W-1:0] ch, input logic [2:0] pl, input logic sp);
    request(ch, pl, sp);
    step(3);
    iFRAME_START = 1'b1;
    step(1);
    iFRAME_START = 1'b0;
  endtask

  task automatic test_reset;
    iRST_N = 1'b0;
    iSEL_CH = CH_W'($urandom); iSEL_PLANE = 3'($urandom); iSPLIT = 1'($urandom);
    iFRAME_START = 1'b1; iX = X_W'($urandom); iDVAL = 1'b1;
    iR = NUM_CH*PIX_W'($urandom); iG = NUM_CH*PIX_W'($urandom); iB = NUM_CH*PIX_W'($urandom);
    iGRAY = {$urandom, $urandom, $urandom};
    step(3);
    checks++;
    if ({oR, oG, oB, oDVAL} !== '0) begin
      errors++; $display("FAIL reset_pixel got %h %h %h dval %b want all 0", oR, oG, oB, oDVAL);
    end
    checks++;
    if ({oCFG_CH, oCFG_PLANE, oCFG_SPLIT, oPENDING, oSEL_ERR} !== '0) begin
      errors++; $display("FAIL reset_cfg got ch %0d pl %0d sp %b pend %b err %b want 0", oCFG_CH, oCFG_PLANE, oCFG_SPLIT, oPENDING, oSEL_ERR);
    end
    request(0, 0, 0);
    iFRAME_START = 1'b0; iDVAL = 1'b0; iX = '0;
    iR = '0; iG = '0; iB = '0; iGRAY = '0;
    iRST_N = 1'b1;
    step(3);
    iR[0 +: PIX_W] = 10'h155; iG[0 +: PIX_W] = 10'h0F0; iB[0 +: PIX_W] = 10'h30C;
    iR[PIX_W +: PIX_W] = 10'h3FF;
    iDVAL = 1'b1;
    step(1);
    checks++;
    if (oDVAL !== 1'b0) begin
      errors++; $display("FAIL latency_early_dval got %b want 0", oDVAL);
    end
    step(1);
    checks++;
    if ({oR, oG, oB} !== {10'h155, 10'h0F0, 10'h30C}) begin
      errors++; $display("FAIL first_pixel got %h %h %h want 155 0f0 30c", oR, oG, oB);
    end
    checks++;
    if (oDVAL !== 1'b1) begin
      errors++; $display("FAIL first_dval got %b want 1", oDVAL);
    end
  endtask

  task automatic test_plane;
    load_cfg(1, 3'd4, 0);
    checks++;
    if ({oCFG_CH, oCFG_PLANE, oCFG_SPLIT} !== {2'd1, 3'd4, 1'b0}) begin
      errors++; $display("FAIL plane_cfg got ch %0d pl %0d sp %b want 1 4 0", oCFG_CH, oCFG_PLANE, oCFG_SPLIT);
    end
    iGRAY = '0;
    iGRAY[(1*NUM_GRAY + 3)*8 +: 8] = 8'hA5;
    iGRAY[(0*NUM_GRAY + 3)*8 +: 8] = 8'h11;
    iDVAL = 1'b1;
    step(2);
    checks++;
    if ({oR, oG, oB} !== {10'h294, 10'h294, 10'h294}) begin
      errors++; $display("FAIL plane_h got %h %h %h want 294 x3", oR, oG, oB);
    end
    checks++;
    if (oPENDING !== 1'b0) begin
      errors++; $display("FAIL plane_pending got %b want 0", oPENDING);
    end
  endtask

  task automatic test_deferred;
    load_cfg(0, 0, 0);
    iR = '0;
    iR[0 +: PIX_W] = 10'h0AA; iR[PIX_W +: PIX_W] = 10'h3CC;
    iDVAL = 1'b1; iX = '0;
    step(2);
    iSEL_CH = 1;
    step(2);
    checks++;
    if (oPENDING !== 1'b0) begin
      errors++; $display("FAIL defer_pending_early got %b want 0", oPENDING);
    end
    step(1);
    checks++;
    if (oPENDING !== 1'b1) begin
      errors++; $display("FAIL defer_pending got %b want 1", oPENDING);
    end
    checks++;
    if (oR !== 10'h0AA) begin
      errors++; $display("FAIL defer_hold got %h want 0aa", oR);
    end
    iFRAME_START = 1'b1;
    step(1);
    iFRAME_START = 1'b0;
    checks++;
    if (oCFG_CH !== 2'd1) begin
      errors++; $display("FAIL defer_cfg got %0d want 1", oCFG_CH);
    end
    step(1);
    checks++;
    if (oR !== 10'h0AA) begin
      errors++; $display("FAIL defer_preload_pixel got %h want 0aa", oR);
    end
    step(1);
    checks++;
    if (oR !== 10'h3CC) begin
      errors++; $display("FAIL defer_switched got %h want 3cc", oR);
    end
    checks++;
    if (oPENDING !== 1'b0) begin
      errors++; $display("FAIL defer_pending_clear got %b want 0", oPENDING);
    end
  endtask

  task automatic test_split;
    load_cfg(0, 0, 1);
    iR = '0;
    iR[0 +: PIX_W] = 10'h100; iR[PIX_W +: PIX_W] = 10'h200;
    iDVAL = 1'b1;
    iX = 11'd319; step(1);
    iX = 11'd320; step(1);
    checks++;
    if (oR !== 10'h100) begin
      errors++; $display("FAIL split_x319 got %h want 100", oR);
    end
    step(1);
    checks++;
    if (oR !== 10'h200) begin
      errors++; $display("FAIL split_x320 got %h want 200", oR);
    end
    load_cfg(1, 0, 1);
    iX = 11'd100; step(1);
    iX = 11'd400; step(1);
    checks++;
    if (oR !== 10'h200) begin
      errors++; $display("FAIL split_wrap_left got %h want 200", oR);
    end
    step(1);
    checks++;
    if (oR !== 10'h100) begin
      errors++; $display("FAIL split_wrap_right got %h want 100", oR);
    end
  endtask

  task automatic test_invalid;
    request(3, 0, 1);
    step(3);
    checks++;
    if (oSEL_ERR !== 1'b1) begin
      errors++; $display("FAIL inv_ch_err got %b want 1", oSEL_ERR);
    end
    checks++;
    if (oPENDING !== 1'b0) begin
      errors++; $display("FAIL inv_ch_pending got %b want 0", oPENDING);
    end
    iFRAME_START = 1'b1; step(1); iFRAME_START = 1'b0;
    checks++;
    if ({oCFG_CH, oCFG_PLANE, oCFG_SPLIT} !== {2'd1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL inv_ch_cfg got ch %0d pl %0d sp %b want 1 0 1", oCFG_CH, oCFG_PLANE, oCFG_SPLIT);
    end
    request(0, 3'd7, 0);
    step(3);
    checks++;
    if (oSEL_ERR !== 1'b1) begin
      errors++; $display("FAIL inv_plane_err got %b want 1", oSEL_ERR);
    end
    iFRAME_START = 1'b1; step(1); iFRAME_START = 1'b0;
    checks++;
    if ({oCFG_CH, oCFG_PLANE, oCFG_SPLIT, oPENDING} !== {2'd1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL inv_plane_cfg got ch %0d pl %0d sp %b pend %b want 1 0 1 0", oCFG_CH, oCFG_PLANE, oCFG_SPLIT, oPENDING);
    end
    request(1, 0, 1);
    step(3);
    checks++;
    if ({oSEL_ERR, oPENDING} !== 2'b00) begin
      errors++; $display("FAIL inv_recover got err %b pend %b want 0 0", oSEL_ERR, oPENDING);
    end
  endtask

  task automatic test_blank;
    iR = '1; iG = '1; iB = '1; iX = 11'd10;
    iDVAL = 1'b0;
    step(2);
    checks++;
    if ({oR, oG, oB} !== '0) begin
      errors++; $display("FAIL blank_pixel got %h %h %h want 0", oR, oG, oB);
    end
    checks++;
    if (oDVAL !== 1'b0) begin
      errors++; $display("FAIL blank_dval got %b want 0", oDVAL);
    end
  endtask

  task automatic test_reset_midframe;
    iR = '0;
    iR[0 +: PIX_W] = 10'h155; iR[PIX_W +: PIX_W] = 10'h2AA;
    iG = '0; iB = '0;
    iX = 11'd400; iDVAL = 1'b1;
    step(2);
    checks++;
    if (oR !== 10'h155) begin
      errors++; $display("FAIL midframe_pre got %h want 155", oR);
    end
    iRST_N = 1'b0;
    #1;
    checks++;
    if ({oR, oDVAL, oCFG_CH, oCFG_SPLIT} !== '0) begin
      errors++; $display("FAIL midframe_async got R %h dval %b ch %0d sp %b want 0", oR, oDVAL, oCFG_CH, oCFG_SPLIT);
    end
    step(1);
    iRST_N = 1'b1;
    step(2);
    checks++;
    if ({oR, oDVAL, oCFG_CH} !== {10'h155, 1'b1, 2'd0}) begin
      errors++; $display("FAIL midframe_resume got R %h dval %b ch %0d want 155 1 0", oR, oDVAL, oCFG_CH);
    end
  endtask

  initial begin
    test_reset();
    test_plane();
    test_deferred();
    test_split();
    test_invalid();
    test_blank();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_channel_mux.md
Name: video_channel_mux

Overview:
Parametrised N-camera display source selector feeding the VGA controller's iRed/iGreen/iBlue inputs. It replaces ad-hoc switch-decoded muxing with a synchronised, frame-boundary-latched selection. Per channel it offers full RGB or any greyscale plane (Y, Cb, Cr, H, S, V, …), plus a split-screen mode that shows two channels side by side. It sits between the per-camera colour-conversion chain and VGA_Controller, in the VGA pixel-clock domain.

Parameters:
NUM_CH, 2, number of camera channels (≥2)
NUM_GRAY, 6, greyscale planes per channel (order Y, Cr, Cb, H, S, V)
PIX_W, 10, RGB component width (≥8)
X_W, 11, width of the VGA X coordinate
SPLIT_X, 320, first X column taken from the second channel in split mode
CH_W, 2, width of the channel-select field (≥ clog2(NUM_CH))

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  asynchronous active-low reset
iSEL_CH  in  CH_W  requested channel (asynchronous, e.g. switches)
iSEL_PLANE  in  3  0 = RGB; k = grey plane k-1
iSPLIT  in  1  requested split-screen enable (asynchronous)
iFRAME_START  in  1  one-cycle pulse at the start of vertical blanking
iX  in  X_W  current VGA X, aligned with iDVAL
iDVAL  in  1  VGA request / pixel valid
iR, iG, iB  in  NUM_CH*PIX_W each  packed RGB, channel 0 in the LSBs
iGRAY  in  NUM_CH*NUM_GRAY*8  packed 8-bit planes; channel c, plane p at bits [(c*NUM_GRAY+p)*8 +: 8]
oR, oG, oB  out  PIX_W each  selected pixel
oDVAL  out  1  iDVAL delayed by 2 cycles
oCFG_CH  out  CH_W  active channel
oCFG_PLANE  out  3  active plane
oCFG_SPLIT  out  1  active split flag
oPENDING  out  1  synchronised request differs from the active configuration
oSEL_ERR  out  1  synchronised request is invalid

Behaviour:
- Reset (asynchronous, iRST_N=0): all outputs 0. Active config is ch 0, plane 0 (RGB), split 0. Synchroniser flops are cleared to 0.
- Synchroniser: 2-flop synchroniser on {iSEL_CH, iSEL_PLANE, iSPLIT}. "req" is the second-stage value. Request-to-req latency is 2 cycles.
- Validity: req is invalid when req_ch ≥ NUM_CH or req_plane > NUM_GRAY.
  - oSEL_ERR is a registered flag equal to "req invalid".
- Config load: on the edge where iFRAME_START=1 and req is valid, the active config is loaded with req.
  - If req is invalid, the active config is held.
  - If iFRAME_START coincides with a req change, the value already in the second stage is the one loaded.
  - The config never changes mid-frame.
- oPENDING (registered) = req valid AND req ≠ active. It clears on the cycle after the load.
- Split source: channel B = (active_ch+1) mod NUM_CH, with the wrap at NUM_CH-1 → 0.
  - Pixel source = active_ch if split=0 or iX < SPLIT_X; otherwise channel B.
- Stage 1 (registered): latch the selected channel's RGB and its selected grey byte (chosen with the stage-0 config), plus iDVAL.
- Stage 2 (registered) formatting:
  - Plane 0: pass RGB unchanged.
  - Plane k≥1: grey g expanded to {g, (PIX_W-8)'b0} and driven on all of oR/oG/oB.
  - If stage-1 dval = 0, oR/oG/oB = 0 (blanking).
- Latency: iX/iDVAL/data to oR/oG/oB/oDVAL is exactly 2 cycles. Throughput is 1 pixel per cycle with no stalls.
- A config load takes effect for the pixel presented in the cycle after the iFRAME_START edge. oCFG_* update on that same edge.
- If iRST_N is asserted mid-frame, outputs drop to 0 immediately. Operation resumes with the default config. Pixels of the remaining frame pass through channel 0 RGB.

Decomposition:
- Shared package: plane encoding constants (PLANE_RGB=0, PLANE_Y=1 … PLANE_V=6) and the default config constants.
- One sub-module: sel_sync_latch. It holds the 2-flop synchroniser, validity check, frame-start config register, oPENDING and oSEL_ERR.
- The top level contains the extraction/mux pipeline only.

Test Plan:
- Reset: hold iRST_N=0 with random inputs → all outputs 0. Release, drive ch0 R=0x155, iDVAL=1 → oR=0x155 exactly 2 cycles later, oDVAL follows.
- Plane select: iSEL_CH=1, iSEL_PLANE=4 (H), pulse iFRAME_START, ch1 H=0xA5 → oR=oG=oB=0x294 (PIX_W=10).
- Deferred switch: change iSEL_CH 0→1 mid-frame → oPENDING=1 from cycle 3, output stays ch0 until iFRAME_START. After the pulse, oCFG_CH=1 and oPENDING=0.
- Split: iSPLIT=1, ch0 R=0x100, ch1 R=0x200, iX=319 then 320 → oR=0x100 then 0x200. With active ch=NUM_CH-1, the right half shows ch0.
- Invalid request: iSEL_CH=3 with NUM_CH=2, or iSEL_PLANE=7 → oSEL_ERR=1, iFRAME_START leaves oCFG_* unchanged, oPENDING=0.
- Blanking: iDVAL=0 with non-zero data → oR=oG=oB=0 and oDVAL=0, 2 cycles later.
